// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Port 0 is the CPU load/store path, port 1 the debug/DMA loader.
// Round-robin between the ports, with an optional lock that lets the
// current owner keep the memory for up to MAX_BURST consecutive grants.
//
// Handshake: a requester raises ri_req and holds req/we/addr/wdata stable
// until ri_gnt is high. The access is performed in the cycle where gnt is
// high, so req && gnt marks a completed transfer. A read returns its data
// on ri_rdata together with a one-cycle ri_rvalid pulse in the next cycle.
// A requester may drop req before it is granted, which withdraws the request.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r1_req,
    input  logic          r0_lock,
    input  logic          r1_lock,
    input  logic          r0_we,
    input  logic          r1_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    // burst_cnt counts grants already given in the current locked burst;
    // it never exceeds MAX_BURST-1 because the grant that would reach
    // MAX_BURST releases the lock instead.
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t        state;
    logic          last;       // port that received the most recent grant
    logic [BW-1:0] burst_cnt;
    logic          gnt0;
    logic          gnt1;

    // Grant decision: round-robin in ARB, owner-only while locked; nothing during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state)
                ST_ARB: begin
                    if (r0_req && r1_req) begin
                        // The port that was not served last wins the tie.
                        gnt0 = last;
                        gnt1 = !last;
                    end else begin
                        gnt0 = r0_req;
                        gnt1 = r1_req;
                    end
                end
                ST_LOCK0: gnt0 = r0_req;
                ST_LOCK1: gnt1 = r1_req;
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign r0_gnt = gnt0;
    assign r1_gnt = gnt1;

    // Memory pin mux: the granted port drives the memory, otherwise all zero.
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (gnt0) begin
            mem_a  = r0_addr;
            mem_wd = r0_wdata;
            mem_we = r0_we;
        end else if (gnt1) begin
            mem_a  = r1_addr;
            mem_wd = r1_wdata;
            mem_we = r1_we;
        end
    end

    // Arbitration state, burst counting and registered read return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ARB;
            last      <= 1'b1;
            burst_cnt <= '0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            // rvalid pulses only for a read granted in the cycle just ending.
            r0_rvalid <= gnt0 && !r0_we;
            r1_rvalid <= gnt1 && !r1_we;
            if (gnt0 && !r0_we) r0_rdata <= mem_rd;
            if (gnt1 && !r1_we) r1_rdata <= mem_rd;

            if (gnt0) last <= 1'b0;
            else if (gnt1) last <= 1'b1;

            case (state)
                ST_ARB: begin
                    // burst_cnt is 0 here; with MAX_BURST=1 the first grant
                    // already ends the burst, so the lock is never entered.
                    if (gnt0 && r0_lock && burst_cnt != BURST_LAST) begin
                        state     <= ST_LOCK0;
                        burst_cnt <= BW'(1);
                    end else if (gnt1 && r1_lock && burst_cnt != BURST_LAST) begin
                        state     <= ST_LOCK1;
                        burst_cnt <= BW'(1);
                    end
                end
                ST_LOCK0: begin
                    // Stay only for another granted, still-locked access below the burst limit.
                    if (gnt0 && r0_lock && burst_cnt != BURST_LAST) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end else begin
                        state     <= ST_ARB;
                        burst_cnt <= '0;
                    end
                end
                ST_LOCK1: begin
                    if (gnt1 && r1_lock && burst_cnt != BURST_LAST) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end else begin
                        state     <= ST_ARB;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state     <= ST_ARB;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, an asynchronous
// reset sequence, and randomized traffic checked against a reference model.
module tb_dmem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          r0_req, r1_req, r0_lock, r1_lock, r0_we, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_lock(r0_lock), .r1_lock(r1_lock),
        .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd)
    );

    // ---------------- memory behind the arbiter ----------------
    function automatic logic [DW-1:0] init_val(int a);
        return (a == 16) ? 32'h0000_DEAD : (32'hC0DE_0000 | 32'(a));
    endfunction

    logic [DW-1:0] mem [0:255];
    logic          mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_we && mem_a[AW-1:8] == '0) begin
            mem[mem_a[7:0]] <= mem_wd;
        end
    end

    assign mem_rd = (mem_a[AW-1:8] == '0) ? mem[mem_a[7:0]] : '0;

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [0:255];
    int            m_owner;   // -1: nobody holds a lock
    int            m_run;     // grants in the current locked burst
    int            m_last;    // most recently granted port
    logic          exp_rv0, exp_rv1;
    logic [DW-1:0] exp_rd0, exp_rd1;
    int            last_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        last_g  = -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic q0, input logic q1, input logic l0, input logic l1,
                         input logic w0, input logic w1, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        r0_req = q0; r1_req = q1; r0_lock = l0; r1_lock = l1;
        r0_we = w0; r1_we = w1;
        r0_addr = 32'(a0); r1_addr = 32'(a1);
        r0_wdata = d0; r1_wdata = d1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 8'h0, 8'h0, '0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: inputs are already driven (just after a posedge).
    // Compare all outputs at the negedge, then advance the model at the posedge.
    task automatic step();
        int g;
        logic lk;
        @(negedge clk);
        if (m_owner >= 0) g = ((m_owner == 0) ? r0_req : r1_req) ? m_owner : -1;
        else if (r0_req && r1_req) g = 1 - m_last;
        else if (r0_req) g = 0;
        else if (r1_req) g = 1;
        else g = -1;
        last_g = g;

        check("gnt0", 32'(r0_gnt), 32'(g == 0));
        check("gnt1", 32'(r1_gnt), 32'(g == 1));
        check("mem_we", 32'(mem_we), (g == 0) ? 32'(r0_we) : (g == 1) ? 32'(r1_we) : 32'd0);
        check("mem_a", mem_a, (g == 0) ? r0_addr : (g == 1) ? r1_addr : 32'd0);
        check("mem_wd", mem_wd, (g == 0) ? r0_wdata : (g == 1) ? r1_wdata : 32'd0);
        check("rvalid0", 32'(r0_rvalid), 32'(exp_rv0));
        check("rvalid1", 32'(r1_rvalid), 32'(exp_rv1));
        check("rdata0", r0_rdata, exp_rd0);
        check("rdata1", r1_rdata, exp_rd1);

        @(posedge clk);
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        if (g == 0) begin
            if (r0_we) ref_mem[r0_addr[7:0]] = r0_wdata;
            else begin exp_rv0 = 1'b1; exp_rd0 = ref_mem[r0_addr[7:0]]; end
        end else if (g == 1) begin
            if (r1_we) ref_mem[r1_addr[7:0]] = r1_wdata;
            else begin exp_rv1 = 1'b1; exp_rd1 = ref_mem[r1_addr[7:0]]; end
        end
        if (g >= 0) begin
            m_last = g;
            m_run  = (m_owner < 0) ? 1 : m_run + 1;
            lk     = (g == 0) ? r0_lock : r1_lock;
            if (lk && m_run < MAX_BURST) m_owner = g;
            else begin m_owner = -1; m_run = 0; end
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst_before;
        logic       q0, q1, l0, l1, w0, w1;
        logic [7:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0] exp_gnt;   // {gnt1, gnt0}
        logic [1:0] exp_rv;    // {rvalid1, rvalid0}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rb, input logic q0, input logic q1, input logic l0, input logic l1,
                       input logic w0, input logic w1, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] eg, input logic [1:0] erv);
        vec_t v;
        v.rst_before = rb; v.q0 = q0; v.q1 = q1; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.exp_gnt = eg; v.exp_rv = erv;
        vecs.push_back(v);
    endtask

    logic p0_q, p0_l, p0_w, p1_q, p1_l, p1_w;
    logic [7:0] p0_a, p1_a;
    logic [DW-1:0] p0_d, p1_d;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        mem_init = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 8'h0, 8'h0, '0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;

        //   rst q0 q1 l0 l1 w0 w1  a0     a1     d0     d1      gnt    rv
        // single read of the preloaded word
        add(1, 1, 0, 0, 0, 0, 0, 8'h10, 8'h00, 32'h0, 32'h0,  2'b01, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0, 32'h0,  2'b00, 2'b01);
        // both reading continuously: strict alternation starting with port 0
        add(1, 1, 1, 0, 0, 0, 0, 8'h01, 8'h02, 32'h0, 32'h0,  2'b01, 2'b00);
        add(0, 1, 1, 0, 0, 0, 0, 8'h01, 8'h02, 32'h0, 32'h0,  2'b10, 2'b01);
        add(0, 1, 1, 0, 0, 0, 0, 8'h01, 8'h02, 32'h0, 32'h0,  2'b01, 2'b10);
        add(0, 1, 1, 0, 0, 0, 0, 8'h01, 8'h02, 32'h0, 32'h0,  2'b10, 2'b01);
        add(0, 1, 1, 0, 0, 0, 0, 8'h01, 8'h02, 32'h0, 32'h0,  2'b01, 2'b10);
        // port 1 writes 0x55 to addr 4 while port 0 waits to read addr 4
        add(0, 1, 1, 0, 0, 0, 1, 8'h04, 8'h04, 32'h0, 32'h55, 2'b10, 2'b01);
        add(0, 1, 0, 0, 0, 0, 0, 8'h04, 8'h04, 32'h0, 32'h0,  2'b01, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0, 32'h0,  2'b00, 2'b01);
        // locked burst by port 0 ends after 4 grants although lock stays high
        add(1, 1, 1, 1, 0, 0, 0, 8'h03, 8'h05, 32'h0, 32'h0,  2'b01, 2'b00);
        add(0, 1, 1, 1, 0, 0, 0, 8'h03, 8'h05, 32'h0, 32'h0,  2'b01, 2'b01);
        add(0, 1, 1, 1, 0, 0, 0, 8'h03, 8'h05, 32'h0, 32'h0,  2'b01, 2'b01);
        add(0, 1, 1, 1, 0, 0, 0, 8'h03, 8'h05, 32'h0, 32'h0,  2'b01, 2'b01);
        add(0, 1, 1, 1, 0, 0, 0, 8'h03, 8'h05, 32'h0, 32'h0,  2'b10, 2'b01);
        // re-lock by port 0, then the owner drops req: one dead cycle
        add(0, 1, 0, 1, 0, 0, 0, 8'h03, 8'h05, 32'h0, 32'h0,  2'b01, 2'b10);
        add(0, 0, 1, 0, 0, 0, 0, 8'h03, 8'h05, 32'h0, 32'h0,  2'b00, 2'b01);
        add(0, 0, 1, 0, 0, 0, 0, 8'h03, 8'h05, 32'h0, 32'h0,  2'b10, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0, 32'h0,  2'b00, 2'b10);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            drive(vecs[i].q0, vecs[i].q1, vecs[i].l0, vecs[i].l1, vecs[i].w0, vecs[i].w1,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            #2;
            check($sformatf("vec%0d_gnt", i), 32'({r1_gnt, r0_gnt}), 32'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_rv", i), 32'({r1_rvalid, r0_rvalid}), 32'(vecs[i].exp_rv));
            if (i == 1) check("vec_rdata_dead", r0_rdata, 32'h0000_DEAD);
            if (i == 9) check("vec_rdata_55", r0_rdata, 32'h0000_0055);
            step();
        end

        // ---- asynchronous reset in the middle of a locked write ----
        do_reset();
        drive(1, 1, 1, 0, 0, 0, 8'h10, 8'h20, '0, '0);
        step();
        drive(1, 1, 1, 0, 1, 0, 8'h08, 8'h20, 32'h88, '0);
        #2;
        check("arst_pre_gnt0", 32'(r0_gnt), 32'd1);
        check("arst_pre_we", 32'(mem_we), 32'd1);
        check("arst_pre_rdata0", r0_rdata, 32'h0000_DEAD);
        rst = 1'b1;
        #1;
        check("arst_gnt0", 32'(r0_gnt), 32'd0);
        check("arst_gnt1", 32'(r1_gnt), 32'd0);
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_mem_a", mem_a, 32'd0);
        check("arst_mem_wd", mem_wd, 32'd0);
        check("arst_rvalid0", 32'(r0_rvalid), 32'd0);
        check("arst_rdata0", r0_rdata, 32'd0);
        @(posedge clk);
        #1;
        check("arst_no_commit", mem[8], init_val(8));
        drive(1, 1, 0, 0, 0, 0, 8'h08, 8'h09, '0, '0);
        rst = 1'b0;
        model_reset();
        #2;
        check("arst_tie_gnt0", 32'(r0_gnt), 32'd1);
        check("arst_tie_gnt1", 32'(r1_gnt), 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 8'h0, 8'h0, '0, '0);
        step();

        // ---- randomized traffic against the reference model ----
        do_reset();
        p0_q = 0; p0_l = 0; p0_w = 0; p0_a = 0; p0_d = 0;
        p1_q = 0; p1_l = 0; p1_w = 0; p1_a = 0; p1_d = 0;
        for (int n = 0; n < 2000; n++) begin
            // A pending, ungranted request stays stable unless withdrawn.
            if (p0_q && last_g != 0) begin
                if ($urandom_range(0, 15) == 0) p0_q = 1'b0;
            end else begin
                p0_q = ($urandom_range(0, 3) != 0);
                p0_l = ($urandom_range(0, 2) == 0);
                p0_w = 1'($urandom_range(0, 1));
                p0_a = 8'($urandom_range(0, 15));
                p0_d = $urandom;
            end
            if (p1_q && last_g != 1) begin
                if ($urandom_range(0, 15) == 0) p1_q = 1'b0;
            end else begin
                p1_q = ($urandom_range(0, 3) != 0);
                p1_l = ($urandom_range(0, 2) == 0);
                p1_w = 1'($urandom_range(0, 1));
                p1_a = 8'($urandom_range(0, 15));
                p1_d = $urandom;
            end
            drive(p0_q, p1_q, p0_l, p1_l, p0_w, p1_w, p0_a, p1_a, p0_d, p1_d);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 8'h0, 8'h0, '0, '0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: port 0 is the CPU load/store path and port 1 is the debug/DMA loader.
- Drives the memory's address, write-data and write-enable pins, and receives its combinational read data.
- Round-robin fairness with an optional bounded lock, so a requester can issue back-to-back bursts.
- Read data is registered and returned one cycle after the grant.

Parameters:
- AW, 32, address width of requester and memory ports.
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive grants to a locked owner (must be ≥1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- r0_req, r1_req  in  1  access request, held until granted.
- r0_lock, r1_lock  in  1  keep ownership after this access.
- r0_we, r1_we  in  1  1 = write, 0 = read.
- r0_addr, r1_addr  in  AW  word address.
- r0_wdata, r1_wdata  in  DW  write data.
- r0_gnt, r1_gnt  out  1  combinational grant; the access happens in this cycle.
- r0_rvalid, r1_rvalid  out  1  one-cycle pulse, the cycle after a granted read.
- r0_rdata, r1_rdata  out  DW  registered read data, held until the next read by that port.
- mem_a  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_rd  in  DW  memory read data (combinational from mem_a).

Behaviour:
- Reset (async, rst=1):
  - state=ARB, last=1 (so port 0 wins the first tie), burst_cnt=0.
  - rvalids=0, rdatas=0.
  - gnts=0, mem_we=0, mem_a=0 and mem_wd=0 are forced combinationally while rst=1, so no write can occur on an edge during reset.
  - Reset mid-burst drops ownership and any pending rvalid.
- State ARB:
  - Only one req: grant it.
  - Both req: grant the port != last.
  - No req: no grant; mem_a=0, mem_wd=0, mem_we=0.
- Granted port i (any state):
  - mem_a=ri_addr, mem_wd=ri_wdata, mem_we=ri_we.
  - Exactly one gnt high at a time.
- Posedge after a grant to i:
  - last<=i.
  - If read: ri_rdata<=mem_rd, ri_rvalid<=1. All rvalids not set this edge clear to 0.
- Transition ARB -> LOCKi: on a granted cycle with ri_lock=1; burst_cnt<=1.
- State LOCKi:
  - Port j≠i is never granted.
  - ri_req=1: grant i, burst_cnt<=burst_cnt+1.
  - Leave LOCKi -> ARB (burst_cnt<=0) when any of:
    - (a) granted with ri_lock=0;
    - (b) granted and burst_cnt+1==MAX_BURST, which forces release even with lock=1;
    - (c) ri_req=0, which gives no grant that cycle (one dead cycle, by design).
  - After a release, last=i, so a waiting port j wins the next ARB tie.
- MAX_BURST=1: lock never holds beyond one grant; state stays ARB.
- Latency:
  - Write commits at the posedge ending the gnt cycle.
  - Read data is valid 1 cycle after gnt.
  - A write followed by a read of the same address in the next grant returns the new data.
- Requester rule: req/we/addr/wdata must be stable while req=1 and gnt=0. Dropping req before gnt is legal (request withdrawn).

Test Plan:
- Reset, then r0_req=1 read addr 0x10 with memory[0x10]=0xDEAD -> r0_gnt=1 in the same cycle; next cycle r0_rvalid=1, r0_rdata=0xDEAD; r1 signals stay 0.
- Both req continuously, reads, no lock -> grants alternate r0, r1, r0, r1 from the first cycle after reset; each rvalid pulses once per grant.
- r1 write 0x55 to addr 4 while r0 waiting; then r0 reads addr 4 -> r0_rdata=0x55; mem_we high only in r1's grant cycle.
- r0_lock=1 with r0_req held, r1_req=1, MAX_BURST=4 -> exactly 4 consecutive r0 grants, then r1 granted; burst ends even though lock stays 1.
- LOCK0 entered, then r0_req drops for one cycle while r1_req=1 -> dead cycle with both gnts 0; next cycle r1 granted.
- Assert rst asynchronously mid-burst during an r0 write cycle -> mem_we=0 immediately, the write is not committed, all outputs return to reset values; after release, a tie goes to r0.
